dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: DEPTH_WORDS, default 64, data memory depth in 32-bit words; power of two, 2..1024.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 p0_req / p1_req  input  1  access request; port 0 = pipeline MEM stage, port 1 = loader/debug port.
REQ-005 pN_we  input  1  1 = write, 0 = read; valid while pN_req.
REQ-006 pN_addr  input  32  byte address; valid while pN_req.
REQ-007 pN_wdata  input  32  write data; valid while pN_req.
REQ-008 pN_gnt  output  1  request accepted this cycle.
REQ-009 pN_rvalid  output  1  response valid, one-cycle pulse.
REQ-010 pN_rdata  output  32  read data; valid with pN_rvalid.
REQ-011 pN_err  output  1  access fault; valid with pN_rvalid.
REQ-012 mem_we / mem_addr[31:0] / mem_wd[31:0]  output  drive the single-port data memory (synchronous write, asynchronous read).
REQ-013 mem_rd  input  32  asynchronous read data from memory.

Function
REQ-014 Grant decision is combinational from current pN_req and registered state; at most one pN_gnt is high per cycle.
REQ-015 Only one port requesting: that port is granted the same cycle.
REQ-016 Both ports requesting: arbitration policy per REQ-029/REQ-030.
REQ-017 A requester holds pN_req and its payload stable until it sees pN_gnt; a request dropped before grant is legal and is ignored.
REQ-018 Grant cycle: mem_addr = granted pN_addr, mem_wd = granted pN_wdata, mem_we = granted pN_we AND NOT fault; with no grant, mem_we = 0, mem_addr = 0, mem_wd = 0.
REQ-019 Fault = pN_addr[1:0] != 0 OR word index pN_addr[31:2] >= DEPTH_WORDS.
REQ-020 A faulting access is granted but never writes memory.
REQ-021 Latency: pN_rvalid asserts exactly 1 cycle after pN_gnt, for both reads and writes.
REQ-022 Read response: pN_rdata = mem_rd sampled at the grant-cycle edge.
REQ-023 Write response and faulting response: pN_rdata = 0.
REQ-024 pN_err = registered fault flag of the granted access.
REQ-025 Back-to-back grants are allowed every cycle with no bubble; the response stage is a single register per port.
REQ-026 The FSM holds the last-owner state: LAST_P0 or LAST_P1; on every grant it moves to the granting port's state, and it holds its state when there is no grant.

Reset
REQ-027 While reset is high: pN_gnt = 0, pN_rvalid = 0, pN_rdata = 0, pN_err = 0, mem_we = 0, FSM = LAST_P1.
REQ-028 Reset asserted mid-transaction drops any pending response; no rvalid is issued for it after reset is released.

Configuration
REQ-029 Macro DMEM_ARB_RR_EN defined: round-robin arbitration; on conflict the port not named by the FSM state wins (LAST_P1 -> p0 wins, LAST_P0 -> p1 wins).
REQ-030 Macro DMEM_ARB_RR_EN undefined: fixed priority; p0 always wins on conflict, and the FSM is still maintained but unused for arbitration.

Structure
REQ-031 Shared package dmem_pkg holds: the FSM state enum (LAST_P0, LAST_P1); DMEM_DEPTH_WORDS = 64; a request struct (we, addr, wdata); and a response struct (rdata, err).
REQ-032 Sub-module dmem_resp_reg, instantiated once per port, registers rvalid, rdata and err with asynchronous reset.

Verification
REQ-033 p0 read of addr 0x10 holding 0xDEADBEEF, p1 idle -> p0_gnt in cycle 0; p0_rvalid = 1 with p0_rdata = 0xDEADBEEF, p0_err = 0 in cycle 1.
REQ-034 p1 write of 0x12345678 to 0x20, then p0 read of 0x20 in the next cycle -> p0_rdata = 0x12345678.
REQ-035 Both ports request every cycle for 4 cycles, out of reset -> RR grant order p0, p1, p0, p1; fixed priority grants p0 four times.
REQ-036 p0 write to 0x102 (misaligned) and p1 write to 0x100 (index 64, out of range) -> both granted, mem_we = 0, pN_err = 1, pN_rdata = 0.
REQ-037 Reset asserted in the cycle after a p0 read grant -> p0_rvalid = 0 throughout reset and after release; next conflict is won by p0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: last-owner FSM state,
// request/response bundles, default depth and the address-fault check.
package dmem_pkg;

    localparam int unsigned DMEM_DEPTH_WORDS = 64;

    typedef enum logic {
        LAST_P0 = 1'b0,
        LAST_P1 = 1'b1
    } owner_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } dmem_resp_t;

    // Misaligned byte address or word index past the end of memory.
    function automatic logic addr_fault(
        input logic [31:0] addr,
        input int unsigned depth
    );
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/dmem_resp_reg.sv
// One-cycle response stage for one arbiter port.
// Ports: clk, reset (async, active high); i_valid/i_resp captured each
// cycle; o_rvalid/o_rdata/o_err present them one cycle later.
module dmem_resp_reg
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  dmem_resp_t  i_resp,
    output logic        o_rvalid,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    logic       r_valid;
    dmem_resp_t r_resp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_resp  <= '0;
        end else begin
            r_valid <= i_valid;
            r_resp  <= i_valid ? i_resp : '0;
        end
    end

    assign o_rvalid = r_valid;
    assign o_rdata  = r_resp.rdata;
    assign o_err    = r_resp.err;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory
// (port 0 = pipeline MEM stage, port 1 = loader/debug).
// Ports: clk, reset (async, active high); pN_req/we/addr/wdata in;
// pN_gnt, pN_rvalid/rdata/err out; mem_we/addr/wd out, mem_rd in.
// Build option: DMEM_ARB_RR_EN selects round-robin on conflict,
// otherwise port 0 has fixed priority.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    owner_e     r_state;
    owner_e     w_state_nxt;
    dmem_req_t  w_req0;
    dmem_req_t  w_req1;
    dmem_req_t  w_sel;
    dmem_resp_t w_resp;
    logic       w_fault0;
    logic       w_fault1;
    logic       w_sel_fault;
    logic       w_any;
    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_p0_wins;

    assign w_req0   = '{we: p0_we, addr: p0_addr, wdata: p0_wdata};
    assign w_req1   = '{we: p1_we, addr: p1_addr, wdata: p1_wdata};
    assign w_fault0 = addr_fault(p0_addr, DEPTH_WORDS);
    assign w_fault1 = addr_fault(p1_addr, DEPTH_WORDS);

`ifdef DMEM_ARB_RR_EN
    // The port that did not own the last grant wins a conflict.
    assign w_p0_wins = (r_state == LAST_P1);
`else
    assign w_p0_wins = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= LAST_P1;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grants are suppressed while reset is high.
    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = r_state;
        if (!reset) begin
            if (p0_req && (!p1_req || w_p0_wins)) begin
                w_gnt0 = 1'b1;
            end else if (p1_req) begin
                w_gnt1 = 1'b1;
            end
        end
        if (w_gnt0) begin
            w_state_nxt = LAST_P0;
        end else if (w_gnt1) begin
            w_state_nxt = LAST_P1;
        end
    end

    always_comb begin
        w_sel       = '0;
        w_sel_fault = 1'b0;
        w_any       = 1'b0;
        unique case (1'b1)
            w_gnt0: begin
                w_sel       = w_req0;
                w_sel_fault = w_fault0;
                w_any       = 1'b1;
            end
            w_gnt1: begin
                w_sel       = w_req1;
                w_sel_fault = w_fault1;
                w_any       = 1'b1;
            end
            default: ;
        endcase
        mem_we       = w_any && w_sel.we && !w_sel_fault;
        mem_addr     = w_sel.addr;
        mem_wd       = w_sel.wdata;
        w_resp.err   = w_sel_fault;
        w_resp.rdata = (w_any && !w_sel.we && !w_sel_fault) ? mem_rd : '0;
    end

    assign p0_gnt = w_gnt0;
    assign p1_gnt = w_gnt1;

    dmem_resp_reg u_resp0 (
        .clk      (clk),
        .reset    (reset),
        .i_valid  (w_gnt0),
        .i_resp   (w_resp),
        .o_rvalid (p0_rvalid),
        .o_rdata  (p0_rdata),
        .o_err    (p0_err)
    );

    dmem_resp_reg u_resp1 (
        .clk      (clk),
        .reset    (reset),
        .i_valid  (w_gnt1),
        .i_resp   (w_resp),
        .o_rvalid (p1_rvalid),
        .o_rdata  (p1_rdata),
        .o_err    (p1_err)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table,
// reset/arbitration sequences and randomized traffic vs a reference model.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
        .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
        .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    // Environment memory: sync write, async read, plus a preload port.
    logic [31:0] mem [0:63];
    logic        pl_we = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_dat = '0;
    assign mem_rd = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (pl_we) mem[pl_idx] <= pl_dat;
        else if (mem_we) mem[mem_addr[7:2]] <= mem_wd;
    end

    // Reference memory contents, maintained by the model.
    logic [31:0] m_mem [0:63];

    typedef struct {
        logic r0; logic w0; logic [31:0] a0; logic [31:0] d0;
        logic r1; logic w1; logic [31:0] a1; logic [31:0] d1;
        logic eg0; logic eg1; logic emwe;
        logic ev0; logic [31:0] ed0; logic ee0;
        logic ev1; logic [31:0] ed1; logic ee1;
    } vec_t;

    function automatic vec_t mkv(
        input logic r0, input logic w0, input logic [31:0] a0,
        input logic [31:0] d0,
        input logic r1, input logic w1, input logic [31:0] a1,
        input logic [31:0] d1,
        input logic eg0, input logic eg1, input logic emwe,
        input logic ev0, input logic [31:0] ed0, input logic ee0,
        input logic ev1, input logic [31:0] ed1, input logic ee1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.eg0 = eg0; v.eg1 = eg1; v.emwe = emwe;
        v.ev0 = ev0; v.ed0 = ed0; v.ee0 = ee0;
        v.ev1 = ev1; v.ed1 = ed1; v.ee1 = ee1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called just after a falling edge; returns after the next one.
    task automatic apply(input string tag, input vec_t v);
        logic [31:0] ea, ed;
        p0_req = v.r0; p0_we = v.w0; p0_addr = v.a0; p0_wdata = v.d0;
        p1_req = v.r1; p1_we = v.w1; p1_addr = v.a1; p1_wdata = v.d1;
        ea = v.eg0 ? v.a0 : (v.eg1 ? v.a1 : 32'h0);
        ed = v.eg0 ? v.d0 : (v.eg1 ? v.d1 : 32'h0);
        #1;
        chk({tag, ".gnt0"}, p0_gnt, v.eg0);
        chk({tag, ".gnt1"}, p1_gnt, v.eg1);
        chk({tag, ".mem_we"}, mem_we, v.emwe);
        chk({tag, ".mem_addr"}, mem_addr, ea);
        chk({tag, ".mem_wd"}, mem_wd, ed);
        @(posedge clk);
        #1;
        chk({tag, ".rvalid0"}, p0_rvalid, v.ev0);
        chk({tag, ".rdata0"}, p0_rdata, v.ed0);
        chk({tag, ".err0"}, p0_err, v.ee0);
        chk({tag, ".rvalid1"}, p1_rvalid, v.ev1);
        chk({tag, ".rdata1"}, p1_rdata, v.ed1);
        chk({tag, ".err1"}, p1_err, v.ee1);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    endtask

    // Two reset cycles with live requests that must be ignored.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        p0_req = 1; p0_we = 1; p0_addr = 32'h10; p0_wdata = 32'hFFFF_0000;
        p1_req = 1; p1_we = 1; p1_addr = 32'h14; p1_wdata = 32'h0000_FFFF;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk({tag, ".rst_gnt0"}, p0_gnt, 0);
            chk({tag, ".rst_gnt1"}, p1_gnt, 0);
            chk({tag, ".rst_mem_we"}, mem_we, 0);
            chk({tag, ".rst_rvalid0"}, p0_rvalid, 0);
            chk({tag, ".rst_rvalid1"}, p1_rvalid, 0);
            chk({tag, ".rst_rdata0"}, p0_rdata, 0);
            chk({tag, ".rst_rdata1"}, p1_rdata, 0);
            chk({tag, ".rst_err0"}, p0_err, 0);
            chk({tag, ".rst_err1"}, p1_err, 0);
            @(negedge clk);
        end
        idle_inputs();
        reset = 1'b0;
    endtask

    task automatic preload(input int idx, input logic [31:0] dat);
        pl_we = 1'b1; pl_idx = 6'(idx); pl_dat = dat;
        m_mem[idx] = dat;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    function automatic bit mfault(input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= 64);
    endfunction

    function automatic logic [31:0] raddr();
        int unsigned k;
        k = $urandom % 8;
        if (k == 0) return 32'(($urandom % 64) * 4 + 1 + $urandom % 3);
        if (k == 1) return 32'((64 + $urandom % 4096) * 4);
        if (k == 2) return 32'h8000_0000 | ($urandom & 32'h7FFF_FFFC);
        return 32'(($urandom % 64) * 4);
    endfunction

    vec_t tbl [11];

    logic        pend [2];
    logic        pwe [2];
    logic [31:0] paddr [2];
    logic [31:0] pwd [2];

    initial begin
        int last;
        int win;
        vec_t v;
        logic [31:0] rd;

        // Directed table; conflict rows start from owner = port 1.
        tbl[0]  = mkv(1,0,32'h10,0, 0,0,0,0, 1,0,0,
                      1,32'hDEADBEEF,0, 0,0,0);
        tbl[1]  = mkv(0,0,0,0, 1,1,32'h20,32'h12345678, 0,1,1,
                      0,0,0, 1,0,0);
        tbl[2]  = mkv(1,0,32'h20,0, 0,0,0,0, 1,0,0,
                      1,32'h12345678,0, 0,0,0);
        tbl[3]  = mkv(0,0,0,0, 1,0,32'h20,0, 0,1,0,
                      0,0,0, 1,32'h12345678,0);
        tbl[4]  = mkv(1,1,32'h102,32'h11111111, 1,1,32'h100,32'h22222222,
                      1,0,0, 1,0,1, 0,0,0);
        tbl[5]  = mkv(0,0,0,0, 1,1,32'h100,32'h22222222, 0,1,0,
                      0,0,0, 1,0,1);
        tbl[6]  = mkv(0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0);
        tbl[7]  = mkv(1,0,32'h0,0, 0,0,0,0, 1,0,0,
                      1,32'hA5A50000,0, 0,0,0);
        tbl[8]  = mkv(0,0,0,0, 1,0,32'hFC,0, 0,1,0,
                      0,0,0, 1,32'h0BADF00D,0);
        tbl[9]  = mkv(1,0,32'h10,0, 1,0,32'hFC,0, 1,0,0,
                      1,32'hDEADBEEF,0, 0,0,0);
        tbl[10] = RR ?
            mkv(1,0,32'h10,0, 1,0,32'hFC,0, 0,1,0,
                0,0,0, 1,32'h0BADF00D,0) :
            mkv(1,0,32'h10,0, 1,0,32'hFC,0, 1,0,0,
                1,32'hDEADBEEF,0, 0,0,0);

        @(negedge clk);
        do_reset("r0");
        preload(0, 32'hA5A50000);
        preload(4, 32'hDEADBEEF);
        preload(8, 32'h0);
        preload(63, 32'h0BADF00D);
        do_reset("r1");

        foreach (tbl[i]) apply($sformatf("tbl%0d", i), tbl[i]);

        // Four cycles of permanent conflict straight out of reset.
        do_reset("r2");
        for (int c = 0; c < 4; c++) begin
            bit p1w;
            p1w = RR && (c % 2 == 1);
            v = mkv(1,0,32'h0,0, 1,0,32'hFC,0, !p1w,p1w,0,
                    !p1w, p1w ? 32'h0 : 32'hA5A50000, 0,
                    p1w, p1w ? 32'h0BADF00D : 32'h0, 0);
            apply($sformatf("conf%0d", c), v);
        end

        // Reset lands while a read response is outstanding.
        do_reset("r3");
        p0_req = 1; p0_we = 0; p0_addr = 32'h10;
        #1;
        chk("rstmid.gnt0", p0_gnt, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rstmid.rvalid_in_rst", p0_rvalid, 0);
        chk("rstmid.gnt_in_rst", p0_gnt, 0);
        @(posedge clk);
        #1;
        chk("rstmid.rvalid_in_rst2", p0_rvalid, 0);
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rstmid.rvalid_after", p0_rvalid, 0);
        @(negedge clk);
        apply("rstmid.conf", mkv(1,0,32'h10,0, 1,0,32'hFC,0, 1,0,0,
                                 1,32'hDEADBEEF,0, 0,0,0));

        // Randomized traffic against the reference model.
        do_reset("r4");
        for (int i = 0; i < 64; i++) preload(i, $urandom);
        last = 1;
        for (int p = 0; p < 2; p++) pend[p] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (pend[p] && ($urandom % 16 == 0)) begin
                    pend[p] = 0;
                end else if (!pend[p] && ($urandom % 10 < 6)) begin
                    pend[p]  = 1;
                    pwe[p]   = 1'($urandom % 2);
                    paddr[p] = raddr();
                    pwd[p]   = $urandom;
                end
            end
            if (pend[0] && pend[1]) win = (RR && last == 0) ? 1 : 0;
            else if (pend[0]) win = 0;
            else if (pend[1]) win = 1;
            else win = -1;
            v = mkv(pend[0], pwe[0], paddr[0], pwd[0],
                    pend[1], pwe[1], paddr[1], pwd[1],
                    win == 0, win == 1, 0, 0,0,0, 0,0,0);
            if (win >= 0) begin
                rd = 0;
                if (!pwe[win] && !mfault(paddr[win]))
                    rd = m_mem[paddr[win] / 4];
                v.emwe = pwe[win] && !mfault(paddr[win]);
                if (win == 0) begin
                    v.ev0 = 1; v.ed0 = rd; v.ee0 = mfault(paddr[0]);
                end else begin
                    v.ev1 = 1; v.ed1 = rd; v.ee1 = mfault(paddr[1]);
                end
            end
            apply($sformatf("rnd%0d", c), v);
            if (win >= 0) begin
                if (v.emwe) m_mem[paddr[win] / 4] = pwd[win];
                last = win;
                pend[win] = 0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
